// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage: default widths, ALU control codes
// ({inverse, funct3}) and the RISC-V funct3 values they are built from.
package ex_stage_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_REG_ADDR_W = 5;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [3:0] ALU_ADD   = {1'b0, F3_ADD_SUB};
  localparam logic [3:0] ALU_SUB   = {1'b1, F3_ADD_SUB};
  localparam logic [3:0] ALU_SLL   = {1'b0, F3_SLL};
  localparam logic [3:0] ALU_JMP   = {1'b1, F3_SLL};
  localparam logic [3:0] ALU_SLT   = {1'b0, F3_SLT};
  localparam logic [3:0] ALU_NSLT  = {1'b1, F3_SLT};
  localparam logic [3:0] ALU_SLTU  = {1'b0, F3_SLTU};
  localparam logic [3:0] ALU_NSLTU = {1'b1, F3_SLTU};
  localparam logic [3:0] ALU_XOR   = {1'b0, F3_XOR};
  localparam logic [3:0] ALU_XNOR  = {1'b1, F3_XOR};
  localparam logic [3:0] ALU_SRL   = {1'b0, F3_SR};
  localparam logic [3:0] ALU_SRA   = {1'b1, F3_SR};
  localparam logic [3:0] ALU_OR    = {1'b0, F3_OR};
  localparam logic [3:0] ALU_AND   = {1'b0, F3_AND};

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: decodes the 4-bit control code; zero flags a result of 0,
// which the execute stage uses as the "branch taken" condition.
module alu_core
  import ex_stage_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [4:0] shamt_s;
  logic       lt_s;
  logic       ltu_s;

  assign shamt_s = op_b[4:0];
  assign lt_s    = ($signed(op_a) < $signed(op_b));
  assign ltu_s   = (op_a < op_b);

  // Operation select; the two unused codes yield zero
  always_comb begin
    result = {XLEN{1'b0}};
    case (alu_ctrl)
      ALU_ADD:   result = op_a + op_b;
      ALU_SUB:   result = op_a - op_b;
      ALU_SLL:   result = op_a << shamt_s;
      ALU_SRL:   result = op_a >> shamt_s;
      ALU_SRA:   result = $unsigned($signed(op_a) >>> shamt_s);
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_NSLT:  result = {{(XLEN-1){1'b0}}, ~lt_s};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, ltu_s};
      ALU_NSLTU: result = {{(XLEN-1){1'b0}}, ~ltu_s};
      ALU_XOR:   result = op_a ^ op_b;
      ALU_XNOR:  result = ~(op_a ^ op_b);
      ALU_OR:    result = op_a | op_b;
      ALU_AND:   result = op_a & op_b;
      ALU_JMP:   result = pc + {{(XLEN-3){1'b0}}, 3'd4};
      default:   result = {XLEN{1'b0}};
    endcase
  end

  assign zero = (result == {XLEN{1'b0}});

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump resolution and a one-entry EX/MEM buffer
// with valid/ready handshake, memory stall and pipeline flush.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_ctrl,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  input  logic [XLEN-1:0]       pc,
  input  logic [XLEN-1:0]       imm,
  input  logic                  is_branch,
  input  logic                  is_jump,
  input  logic                  is_jalr,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [XLEN-1:0]       store_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic [XLEN-1:0]       out_store_data,
  output logic                  redirect,
  output logic [XLEN-1:0]       redirect_pc
);

  logic [XLEN-1:0] alu_result_s;
  logic            alu_zero_s;
  logic [XLEN-1:0] wb_result_s;
  logic [XLEN-1:0] target_s;
  logic            take_s;
  logic            capture_s;

  alu_core #(.XLEN(XLEN)) u_alu (
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .pc       (pc),
    .result   (alu_result_s),
    .zero     (alu_zero_s)
  );

  assign in_ready  = !out_valid || out_ready;
  assign capture_s = in_valid && in_ready && !flush;

  // Redirect decision and target; jumps always link with pc+4
  always_comb begin
    wb_result_s = alu_result_s;
    take_s      = 1'b0;
    if (is_jump) begin
      wb_result_s = pc + {{(XLEN-3){1'b0}}, 3'd4};
      take_s      = 1'b1;
    end else if (is_branch) begin
      take_s = alu_zero_s;
    end else begin
      take_s = 1'b0;
    end
    if (is_jalr) begin
      target_s = (op_a + imm) & {{(XLEN-1){1'b1}}, 1'b0};
    end else begin
      target_s = pc + imm;
    end
  end

  // EX/MEM buffer; redirect is a single-cycle pulse tied to the capture edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      redirect       <= 1'b0;
      redirect_pc    <= {XLEN{1'b0}};
      result         <= {XLEN{1'b0}};
      out_rd         <= {REG_ADDR_W{1'b0}};
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_store_data <= {XLEN{1'b0}};
    end else if (flush) begin
      out_valid <= 1'b0;
      redirect  <= 1'b0;
    end else if (capture_s) begin
      out_valid      <= 1'b1;
      redirect       <= take_s;
      redirect_pc    <= target_s;
      result         <= wb_result_s;
      out_rd         <= rd;
      out_reg_write  <= reg_write && !is_branch;
      out_mem_read   <= mem_read && !is_branch;
      out_mem_write  <= mem_write && !is_branch;
      out_store_data <= store_data;
    end else begin
      redirect <= 1'b0;
      if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed steps plus randomized traffic
// compared against a transaction-level reference model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b, pc, imm, store_data;
  logic        is_branch, is_jump, is_jalr;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write, flush;
  logic        out_valid, out_ready;
  logic [31:0] result, out_store_data, redirect_pc;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write, redirect;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model of the EX/MEM entry as seen by MEM
  logic        m_valid = 1'b0, m_redirect = 1'b0, m_rw = 1'b0, m_mr = 1'b0, m_mw = 1'b0;
  logic [31:0] m_result = 32'd0, m_rpc = 32'd0, m_sd = 32'd0;
  logic [4:0]  m_rd = 5'd0;

  ex_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .pc(pc), .imm(imm),
    .is_branch(is_branch), .is_jump(is_jump), .is_jalr(is_jalr), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .store_data(store_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_store_data(out_store_data),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] p);
    longint sa, sb;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32'd32);
    case (c)
      4'd0:    return a + b;
      4'd8:    return a - b;
      4'd1:    return a * (32'd1 << sh);
      4'd5:    return a / (32'd1 << sh);
      4'd13:   return 32'(sa >>> sh);
      4'd2:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd10:   return (sa < sb) ? 32'd0 : 32'd1;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd11:   return (a < b) ? 32'd0 : 32'd1;
      4'd4:    return a ^ b;
      4'd12:   return ~(a ^ b);
      4'd6:    return a | b;
      4'd7:    return a & b;
      4'd9:    return p + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] im,
                        input logic br, input logic j, input logic jr);
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b; pc = p; imm = im;
    is_branch = br; is_jump = j; is_jalr = jr;
    rd = 5'd7; reg_write = 1'b1; mem_read = 1'b0; mem_write = 1'b1; store_data = a ^ 32'h5A5A_0000;
  endtask

  // one clock: check in_ready, advance model and DUT, check the entry
  task automatic cycle(input string tag);
    logic        exp_rdy, cap, take;
    logic [31:0] r, tgt;
    #1;
    exp_rdy = !m_valid || out_ready;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
    cap  = in_valid && exp_rdy && !flush;
    r    = is_jump ? pc + 32'd4 : ref_alu(alu_ctrl, op_a, op_b, pc);
    take = is_jump || (is_branch && (r == 32'd0));
    tgt  = is_jalr ? ((op_a + imm) & 32'hFFFF_FFFE) : pc + imm;
    @(posedge clk); #1;
    if (flush) begin
      m_valid = 1'b0; m_redirect = 1'b0;
    end else if (cap) begin
      m_valid = 1'b1; m_redirect = take; m_rpc = tgt; m_result = r; m_rd = rd;
      m_rw = reg_write && !is_branch; m_mr = mem_read && !is_branch;
      m_mw = mem_write && !is_branch; m_sd = store_data;
    end else begin
      m_redirect = 1'b0;
      if (out_ready) m_valid = 1'b0;
    end
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, m_redirect});
    if (m_redirect) chk({tag, ".redirect_pc"}, redirect_pc, m_rpc);
    if (m_valid) begin
      chk({tag, ".result"}, result, m_result);
      chk({tag, ".out_rd"}, {27'd0, out_rd}, {27'd0, m_rd});
      chk({tag, ".wr_flags"}, {29'd0, out_reg_write, out_mem_read, out_mem_write},
          {29'd0, m_rw, m_mr, m_mw});
      chk({tag, ".store_data"}, out_store_data, m_sd);
    end
  endtask

  logic [3:0]  sweep_code [7] = '{4'd0, 4'd8, 4'd13, 4'd5, 4'd2, 4'd3, 4'd12};
  logic [31:0] sweep_exp  [7] = '{32'hFFFF_FFF4, 32'hFFFF_FFEC, 32'hFFFF_FFFF,
                                  32'h0FFF_FFFF, 32'd1, 32'd0, 32'h0000_000B};

  initial begin
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_op(4'd0, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.redirect", {31'd0, redirect}, 32'd0);
    chk("reset.result", result, 32'd0);
    chk("reset.data", {27'd0, out_rd} | out_store_data | redirect_pc, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      set_op(sweep_code[i], 32'hFFFF_FFF0, 32'h4, 32'h40, 32'h8, 1'b0, 1'b0, 1'b0);
      cycle("sweep");
      chk($sformatf("sweep_const_%0d", i), result, sweep_exp[i]);
    end

    set_op(4'b1100, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0);
    cycle("bne");
    chk("bne.result", result, 32'hFFFF_FFFF);
    chk("bne.redirect", {31'd0, redirect}, 32'd0);
    set_op(4'b0100, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0);
    cycle("beq");
    chk("beq.redirect", {31'd0, redirect}, 32'd1);
    chk("beq.redirect_pc", redirect_pc, 32'h120);
    chk("beq.reg_write", {31'd0, out_reg_write}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b0;
    cycle("beq_after");
    chk("beq.pulse_end", {31'd0, redirect}, 32'd0);
    out_ready = 1'b1;
    cycle("drain");

    set_op(4'b1001, 32'h1003, 32'd0, 32'h200, 32'd4, 1'b0, 1'b1, 1'b1);
    cycle("jalr");
    chk("jalr.result", result, 32'h204);
    chk("jalr.redirect_pc", redirect_pc, 32'h1006);

    set_op(4'd0, 32'd1, 32'd2, 32'h300, 32'd0, 1'b0, 1'b0, 1'b0);
    cycle("bp_a");
    out_ready = 1'b0;
    set_op(4'd8, 32'd10, 32'd3, 32'h304, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("bp_stall");
    chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp.held", result, 32'd3);
    out_ready = 1'b1;
    cycle("bp_release");
    chk("bp.no_bubble", {31'd0, out_valid}, 32'd1);
    chk("bp.next", result, 32'd7);

    out_ready = 1'b0;
    set_op(4'b1001, 32'd0, 32'd0, 32'h400, 32'h40, 1'b0, 1'b1, 1'b0);
    cycle("fl_hold");
    flush = 1'b1;
    cycle("flush");
    chk("flush.out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush.redirect", {31'd0, redirect}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    cycle("flush_after");

    for (int i = 0; i < 300; i++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(0, 3));
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      alu_ctrl   = 4'($urandom);
      op_a       = $urandom;
      op_b       = ($urandom_range(0, 3) == 0) ? op_a : $urandom;
      pc         = $urandom & 32'hFFFF_FFFC;
      imm        = $urandom;
      is_branch  = (kind == 2'd1);
      is_jump    = (kind >= 2'd2);
      is_jalr    = (kind == 2'd3);
      rd         = 5'($urandom);
      reg_write  = 1'($urandom);
      mem_read   = 1'($urandom);
      mem_write  = 1'($urandom);
      store_data = $urandom;
      cycle("rand");
    end

    set_op(4'd6, 32'hF0, 32'h0F, 32'h500, 32'd0, 1'b0, 1'b0, 1'b0);
    flush = 1'b0; out_ready = 1'b0;
    cycle("pre_reset");
    #2 reset_n = 1'b0;
    #1;
    chk("midreset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset.result", result, 32'd0);
    reset_n = 1'b1;
    m_valid = 1'b0; m_redirect = 1'b0;
    in_valid = 1'b0;
    cycle("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
